// File: rtl/des_key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// des_key_sched_ctrl
//
// Iterative DES round-key sequencer. A single 56-bit C/D register is loaded
// from PC1(key). It is then rotated in place once per accepted transfer. The
// current subkey is PC2(C/D), offered on a valid/ready handshake in round
// order.
//
// Ports
//   clk       : single clock, rising edge
//   rst_n     : synchronous active-low reset
//   start     : request a new schedule (sampled only while ready=1)
//   key       : 64-bit DES key, bit 0 = DES bit 1 (MSB); parity bits ignored
//   decrypt   : 0 = K1..K16, 1 = K16..K1 (only when DES_KS_DECRYPT_EN)
//   ready     : idle, start will be accepted
//   k_valid   : k_subkey / k_round are valid
//   k_ready   : consumer accepts the current subkey
//   k_subkey  : PC2 of the current C/D register (combinational)
//   k_round   : DES round number 1..16 of k_subkey, 0 while idle
//   done      : one-cycle pulse after the 16th transfer
//
// Build option
//   DES_KS_DECRYPT_EN : when defined, decrypt is honoured. This adds the
//                       right-rotate path and the direction register. When it
//                       is undefined, decrypt is ignored and the order is
//                       always K1..K16.
//
// Also contains the fixed DES permutations PC1 and PC2.
// -----------------------------------------------------------------------------

module des_key_sched_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [0:63] key,
  input  logic        decrypt,
  output logic        ready,
  output logic        k_valid,
  input  logic        k_ready,
  output logic [0:47] k_subkey,
  output logic [4:0]  k_round,
  output logic        done
);

  // state   | meaning
  // --------+-----------------------------------------------------------
  // ST_IDLE | waiting for start; ready=1, k_valid=0, k_round=0, C/D=0
  // ST_RUN  | offering subkey of round_q; advances on k_valid & k_ready
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [0:55] cd_q, cd_d;
  logic [0:55] pc1_cd;
  logic [4:0]  round_q, round_d;
  logic        done_q, done_d;
  logic        xfer;
  logic        last_round;

`ifdef DES_KS_DECRYPT_EN
  logic        dir_q, dir_d;
`else
  logic        unused_decrypt;
  assign unused_decrypt = decrypt;
`endif

  PC1 u_pc1 (
    .key_i (key),
    .cd_o  (pc1_cd)
  );

  PC2 u_pc2 (
    .cd_i  (cd_q),
    .k_o   (k_subkey)
  );

  // Rounds 1, 2, 9 and 16 shift by one. All other rounds shift by two.
  function automatic logic two_shift(input logic [4:0] r);
    return !((r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16));
  endfunction

  // C (bits 0..27) and D (bits 28..55) are independent 28-bit rings. Bit 0 is
  // the MSB, so a left rotate moves bit 1 into position 0.
  function automatic logic [0:55] rotl(input logic [0:55] cd, input logic two);
    logic [0:27] c;
    logic [0:27] d;
    c = cd[0:27];
    d = cd[28:55];
    if (two) return {c[2:27], c[0:1], d[2:27], d[0:1]};
    return {c[1:27], c[0], d[1:27], d[0]};
  endfunction

`ifdef DES_KS_DECRYPT_EN
  function automatic logic [0:55] rotr(input logic [0:55] cd, input logic two);
    logic [0:27] c;
    logic [0:27] d;
    c = cd[0:27];
    d = cd[28:55];
    if (two) return {c[26:27], c[0:25], d[26:27], d[0:25]};
    return {c[27], c[0:26], d[27], d[0:26]};
  endfunction

  assign last_round = dir_q ? (round_q == 5'd1) : (round_q == 5'd16);
`else
  assign last_round = (round_q == 5'd16);
`endif

  assign ready   = (state_q == ST_IDLE);
  assign k_valid = (state_q == ST_RUN);
  assign k_round = round_q;
  assign done    = done_q;
  assign xfer    = k_valid & k_ready;

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    round_d = round_q;
    done_d  = 1'b0;
`ifdef DES_KS_DECRYPT_EN
    dir_d   = dir_q;
`endif

    if (state_q == ST_IDLE) begin
      if (start) begin
        state_d = ST_RUN;
`ifdef DES_KS_DECRYPT_EN
        dir_d = decrypt;
        if (decrypt) begin
          // The 16 shifts total 28 positions, so CD16 equals CD0.
          cd_d    = pc1_cd;
          round_d = 5'd16;
        end else begin
          cd_d    = rotl(pc1_cd, 1'b0);
          round_d = 5'd1;
        end
`else
        cd_d    = rotl(pc1_cd, 1'b0);
        round_d = 5'd1;
`endif
      end
    end else begin
      if (xfer) begin
        if (last_round) begin
          // Clear C/D so that k_subkey reads PC2(0)=0 while idle.
          state_d = ST_IDLE;
          cd_d    = '0;
          round_d = 5'd0;
          done_d  = 1'b1;
        end else begin
`ifdef DES_KS_DECRYPT_EN
          if (dir_q) begin
            // Undo the shift that produced the current round.
            cd_d    = rotr(cd_q, two_shift(round_q));
            round_d = round_q - 5'd1;
          end else begin
            cd_d    = rotl(cd_q, two_shift(round_q + 5'd1));
            round_d = round_q + 5'd1;
          end
`else
          cd_d    = rotl(cd_q, two_shift(round_q + 5'd1));
          round_d = round_q + 5'd1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cd_q    <= '0;
      round_q <= 5'd0;
      done_q  <= 1'b0;
`ifdef DES_KS_DECRYPT_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      done_q  <= done_d;
`ifdef DES_KS_DECRYPT_EN
      dir_q   <= dir_d;
`endif
    end
  end

endmodule

// -----------------------------------------------------------------------------
// PC1 : DES permuted choice 1. Selects 56 bits from the 64-bit key and drops
//       the parity bits.
//   key_i : 64-bit key, bit 0 = DES bit 1
//   cd_o  : 56-bit C/D value, C = bits 0..27, D = bits 28..55
// -----------------------------------------------------------------------------
module PC1 (
  input  logic [0:63] key_i,
  output logic [0:55] cd_o
);

  localparam int TBL [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  for (genvar i = 0; i < 56; i++) begin : g_bit
    assign cd_o[i] = key_i[TBL[i] - 1];
  end

  logic [7:0] unused_parity;
  assign unused_parity = {key_i[7],  key_i[15], key_i[23], key_i[31],
                          key_i[39], key_i[47], key_i[55], key_i[63]};

endmodule

// -----------------------------------------------------------------------------
// PC2 : DES permuted choice 2. Compresses C/D into a 48-bit subkey.
//   cd_i : 56-bit C/D value
//   k_o  : 48-bit round subkey, bit 0 = DES bit 1
// -----------------------------------------------------------------------------
module PC2 (
  input  logic [0:55] cd_i,
  output logic [0:47] k_o
);

  localparam int TBL [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  for (genvar i = 0; i < 48; i++) begin : g_bit
    assign k_o[i] = cd_i[TBL[i] - 1];
  end

  // These C/D positions are never selected into a subkey.
  logic [7:0] unused_cd;
  assign unused_cd = {cd_i[8],  cd_i[17], cd_i[21], cd_i[24],
                      cd_i[34], cd_i[37], cd_i[42], cd_i[53]};

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
module tb_des_key_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [0:63] key;
  logic        decrypt;
  logic        ready;
  logic        k_valid;
  logic        k_ready;
  logic [0:47] k_subkey;
  logic [4:0]  k_round;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef DES_KS_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  localparam logic [0:63] KEY_A = 64'h133457799BBCDFF1;

  typedef struct {
    logic [4:0]  rnd;
    logic [47:0] sub;
  } vec_t;

  vec_t vecs [16];

  des_key_sched_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key      (key),
    .decrypt  (decrypt),
    .ready    (ready),
    .k_valid  (k_valid),
    .k_ready  (k_ready),
    .k_subkey (k_subkey),
    .k_round  (k_round),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge while the DUT is idle. Returns one negedge after the
  // accept edge, when the first subkey is on the outputs.
  task automatic issue_start(input logic [0:63] k, input logic dec);
    start   = 1'b1;
    key     = k;
    decrypt = dec;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Full sweep with k_ready=1. When pulse_from is nonzero, start is held high
  // with key 0 from that round onward, including the last-transfer cycle.
  // Returns in the done cycle.
  task automatic run_sweep(input logic [0:63] k, input logic dec,
                           input int pulse_from, input string tag);
    int  idx;
    logic rev;
    rev = dec & DEC_EN;
    k_ready = 1'b1;
    issue_start(k, dec);
    for (int i = 0; i < 16; i++) begin
      idx = rev ? 15 - i : i;
      chk({tag, " valid"},  k_valid,  1);
      chk({tag, " ready"},  ready,    0);
      chk({tag, " round"},  k_round,  vecs[idx].rnd);
      chk({tag, " subkey"}, k_subkey, vecs[idx].sub);
      if (pulse_from != 0 && (i + 1) >= pulse_from) begin
        start = 1'b1;
        key   = '0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " done"},      done,    1);
    chk({tag, " done_rdy"},  ready,   1);
    chk({tag, " done_val"},  k_valid, 0);
    chk({tag, " done_rnd"},  k_round, 0);
  endtask

  task automatic settle(input string tag);
    @(negedge clk);
    chk({tag, " done_clr"}, done, 0);
    chk({tag, " idle_key"}, k_subkey, 0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    k_ready = 1'b1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " drain_done"}, done, 1);
  endtask

  initial begin
    int exp_i;
    int cyc;
    int n_done;

    vecs[0]  = '{5'd1,  48'h1B02EFFC7072};
    vecs[1]  = '{5'd2,  48'h79AED9DBC9E5};
    vecs[2]  = '{5'd3,  48'h55FC8A42CF99};
    vecs[3]  = '{5'd4,  48'h72ADD6DB351D};
    vecs[4]  = '{5'd5,  48'h7CEC07EB53A8};
    vecs[5]  = '{5'd6,  48'h63A53E507B2F};
    vecs[6]  = '{5'd7,  48'hEC84B7F618BC};
    vecs[7]  = '{5'd8,  48'hF78A3AC13BFB};
    vecs[8]  = '{5'd9,  48'hE0DBEBEDE781};
    vecs[9]  = '{5'd10, 48'hB1F347BA464F};
    vecs[10] = '{5'd11, 48'h215FD3DED386};
    vecs[11] = '{5'd12, 48'h7571F59467E9};
    vecs[12] = '{5'd13, 48'h97C5D1FABA41};
    vecs[13] = '{5'd14, 48'h5F43B7F2E73A};
    vecs[14] = '{5'd15, 48'hBF918D3D3F0A};
    vecs[15] = '{5'd16, 48'hCB3D8B0E17F5};

    rst_n   = 1'b0;
    start   = 1'b0;
    key     = '0;
    decrypt = 1'b0;
    k_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst ready",  ready,    1);
    chk("rst valid",  k_valid,  0);
    chk("rst round",  k_round,  0);
    chk("rst done",   done,     0);
    chk("rst subkey", k_subkey, 0);

    run_sweep(KEY_A, 1'b0, 0, "enc");
    settle("enc");

    // With the macro off this must come out in encrypt order.
    run_sweep(KEY_A, 1'b1, 0, "dec");
    settle("dec");

    // Backpressure: every cycle must show the next unaccepted subkey.
    issue_start(KEY_A, 1'b0);
    exp_i = 0;
    cyc   = 0;
    while (exp_i < 16 && cyc < 400) begin
      chk("bp valid",  k_valid,  1);
      chk("bp round",  k_round,  vecs[exp_i].rnd);
      chk("bp subkey", k_subkey, vecs[exp_i].sub);
      k_ready = 1'($urandom_range(0, 1));
      if (k_ready) exp_i++;
      cyc++;
      @(negedge clk);
    end
    k_ready = 1'b1;
    chk("bp transfers", exp_i, 16);
    chk("bp done",      done,  1);
    settle("bp");

    // Start held from round 3 through the last-transfer cycle, then a new
    // start with key 0 in the done cycle.
    run_sweep(KEY_A, 1'b0, 3, "coll");
    issue_start(64'h0, 1'b0);
    chk("coll2 valid",  k_valid,  1);
    chk("coll2 round",  k_round,  1);
    chk("coll2 subkey", k_subkey, 0);
    drain("coll2");
    settle("coll2");

    // Reset during round 7.
    issue_start(KEY_A, 1'b0);
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("mrst round7", k_round, 7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst valid",  k_valid,  0);
    chk("mrst round",  k_round,  0);
    chk("mrst ready",  ready,    1);
    chk("mrst done",   done,     0);
    chk("mrst subkey", k_subkey, 0);
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("mrst no_done", n_done, 0);

    run_sweep(KEY_A, 1'b0, 0, "post_rst");
    settle("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
